// File: rtl/uart_rx_pkg.sv
// Shared helpers and payload types for the UART receive path.
package uart_rx_pkg;

    function automatic int unsigned calc_cpb(input int unsigned clk_hz, input int unsigned bit_rate);
        return clk_hz / bit_rate;
    endfunction

    // Counter width able to hold values 0..n-1, never narrower than one bit.
    function automatic int unsigned width_for(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic busy;
        logic frame_err;
        logic overrun;
    } rx_status_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead FIFO with extra-MSB pointers; simultaneous push/pop on full is accepted.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = width_for(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronise, frame, mid-bit sample, stop check, buffer into a valid/ready byte stream.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned BIT_RATE     = 115200,
    parameter int unsigned CLK_HZ       = 10000000,
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    uart_rxd,
    output logic [PAYLOAD_BITS-1:0] rx_data,
    output logic                    rx_valid,
    input  logic                    rx_ready,
    output logic                    rx_busy,
    output logic                    rx_frame_err,
    output logic                    rx_overrun
);

    localparam int unsigned CPB        = calc_cpb(CLK_HZ, BIT_RATE);
    localparam int unsigned HALF       = CPB / 2;
    localparam int unsigned CW         = width_for(CPB);
    localparam int unsigned FRAME_BITS = PAYLOAD_BITS + STOP_BITS;
    localparam int unsigned IW         = $clog2(FRAME_BITS) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic sync1, sync2, prev;
    logic fall_c;

    state_t                  state, state_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic [IW-1:0]           idx, idx_n;
    logic [PAYLOAD_BITS-1:0] shreg, shreg_n;
    logic                    stop_bad, stop_bad_n;
    logic                    push_c;
    logic                    frame_err_c;
    logic                    tick_c;

    rx_status_t status, status_n;

    logic                    fifo_full, fifo_empty, pop_c;
    logic [PAYLOAD_BITS-1:0] fifo_head;

    // Two-flop synchroniser plus one history flop for falling-edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= uart_rxd;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign fall_c = prev & ~sync2;
    assign tick_c = (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            shreg    <= '0;
            stop_bad <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            shreg    <= shreg_n;
            stop_bad <= stop_bad_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        idx_n       = idx;
        shreg_n     = shreg;
        stop_bad_n  = stop_bad;
        push_c      = 1'b0;
        frame_err_c = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (fall_c) begin
                    state_n = S_START;
                    cnt_n   = CW'(HALF - 1);
                end
            end

            S_START: begin
                if (!tick_c) begin
                    cnt_n = cnt - CW'(1);
                end else if (!sync2) begin
                    state_n = S_DATA;
                    cnt_n   = CW'(CPB - 1);
                    idx_n   = '0;
                end else begin
                    state_n = S_IDLE;
                end
            end

            S_DATA: begin
                if (!tick_c) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    shreg_n    = {sync2, shreg[PAYLOAD_BITS-1:1]};
                    cnt_n      = CW'(CPB - 1);
                    idx_n      = idx + IW'(1);
                    stop_bad_n = 1'b0;
                    if (idx == IW'(PAYLOAD_BITS - 1)) state_n = S_STOP;
                end
            end

            // Earlier stop bits accumulate into stop_bad; the final one decides.
            S_STOP: begin
                if (!tick_c) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    cnt_n = CW'(CPB - 1);
                    idx_n = idx + IW'(1);
                    if (idx == IW'(FRAME_BITS - 1)) begin
                        if (stop_bad || !sync2) begin
                            frame_err_c = 1'b1;
                            state_n     = S_BREAK;
                        end else begin
                            push_c  = 1'b1;
                            state_n = S_IDLE;
                        end
                    end else begin
                        stop_bad_n = stop_bad | ~sync2;
                    end
                end
            end

            S_BREAK: begin
                if (sync2) state_n = S_IDLE;
            end

            default: state_n = S_IDLE;
        endcase
    end

    assign pop_c = rx_valid & rx_ready;

    always_comb begin
        status_n           = '0;
        status_n.busy      = (state_n != S_IDLE);
        status_n.frame_err = frame_err_c;
        status_n.overrun   = push_c & fifo_full & ~pop_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) status <= '0;
        else     status <= status_n;
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PAYLOAD_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_c),
        .push_data (shreg_n),
        .pop       (pop_c),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rx_valid     = ~fifo_empty;
    assign rx_data      = rx_valid ? fifo_head : '0;
    assign rx_busy      = status.busy;
    assign rx_frame_err = status.frame_err;
    assign rx_overrun   = status.overrun;

endmodule
